// File: rtl/cmd_handshake_src.sv
// Source-side endpoint of the PCLK command path: queues host commands and launches
// each as a 4-phase req/ack handshake, with ack timeout, abort/flush and guarded release.
`timescale 1ns/1ps
module cmd_handshake_src #(
    parameter int CW          = 3,
    parameter int AW          = 10,
    parameter int DW          = 10,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic          PCLK,
    input  logic          RESETn_pclk,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [CW-1:0] CMD,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] WDATA,
    input  logic          ABORT,
    output logic [CW-1:0] CMD_REG_pclk,
    output logic [AW-1:0] ADDR_REG_pclk,
    output logic [DW-1:0] WDATA_REG_pclk,
    output logic          req_pclk,
    input  logic          ack_sclk,
    input  logic [DW-1:0] RDATA_sclk,
    output logic          rsp_valid,
    output logic [DW-1:0] RDATA_pclk,
    output logic          RESP_pclk,
    output logic          busy
);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int EW    = CW + AW + DW;
    localparam int GUARD = 2 * SYNC_STAGES + 2;
    localparam int GW    = $clog2(GUARD + 1);
    localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST   = GW'(GUARD - 1);
    localparam logic [PW:0]   FULL_LVL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REQ, S_DROP} state_t;

    state_t                 state, state_nxt;
    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [EW-1:0]          head;
    logic [PW:0]            wr_ptr, rd_ptr;
    logic                   full, empty, push, pop;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [TW-1:0]          to_cnt;
    logic [GW-1:0]          guard_cnt;
    logic                   timed_out, req_set, req_clr, rsp_ok, rsp_err;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = ((wr_ptr - rd_ptr) == FULL_LVL);
    assign cmd_ready = ~full & RESETn_pclk;
    // IDLE commands are acknowledged to the host but never occupy a slot
    assign push      = cmd_valid & cmd_ready & ~ABORT & (CMD != '0);
    assign head      = mem[rd_ptr[PW-1:0]];
    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign busy      = (state != S_IDLE) | ~empty;
    assign timed_out = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr[PW-1:0]] <= {CMD, ADDR, WDATA};
    end

    always_ff @(posedge PCLK) begin
        if (!RESETn_pclk || ABORT) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!RESETn_pclk) ack_sync <= '0;
        else              ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_sclk};
    end

    always_ff @(posedge PCLK) begin
        if (!RESETn_pclk) state <= S_IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        req_set   = 1'b0;
        req_clr   = 1'b0;
        rsp_ok    = 1'b0;
        rsp_err   = 1'b0;
        case (state)
            S_IDLE: if (!ABORT && !empty) begin
                pop       = 1'b1;
                state_nxt = S_LOAD;
            end
            S_LOAD: if (ABORT) begin
                state_nxt = S_IDLE;
            end else if (!ack_s) begin
                req_set   = 1'b1;
                state_nxt = S_REQ;
            end
            // a same-cycle ack outranks both abort and timeout
            S_REQ: if (ack_s) begin
                rsp_ok    = 1'b1;
                req_clr   = 1'b1;
                state_nxt = S_DROP;
            end else if (ABORT || timed_out) begin
                rsp_err   = 1'b1;
                req_clr   = 1'b1;
                state_nxt = S_DROP;
            end
            S_DROP: if (!ack_s && guard_cnt == G_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!RESETn_pclk) begin
            CMD_REG_pclk   <= '0;
            ADDR_REG_pclk  <= '0;
            WDATA_REG_pclk <= '0;
            req_pclk       <= 1'b0;
            rsp_valid      <= 1'b0;
            RDATA_pclk     <= '0;
            RESP_pclk      <= 1'b0;
            to_cnt         <= '0;
            guard_cnt      <= '0;
        end else begin
            rsp_valid <= rsp_ok | rsp_err;
            if (pop) {CMD_REG_pclk, ADDR_REG_pclk, WDATA_REG_pclk} <= head;
            if (req_set)      req_pclk <= 1'b1;
            else if (req_clr) req_pclk <= 1'b0;
            if (rsp_ok) begin
                RDATA_pclk <= RDATA_sclk;
                RESP_pclk  <= 1'b0;
            end else if (rsp_err) begin
                RDATA_pclk <= '0;
                RESP_pclk  <= 1'b1;
            end
            if (req_set)                            to_cnt <= '0;
            else if (state == S_REQ && to_cnt != '1) to_cnt <= to_cnt + 1'b1;
            // guard counts consecutive low-ack cycles; any late ack restarts it
            if (state != S_DROP || ack_s)  guard_cnt <= '0;
            else if (guard_cnt != G_LAST)  guard_cnt <= guard_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cmd_handshake_src.sv
// Bench for cmd_handshake_src: directed scenarios plus a transaction/timestamp model
// of the handshake checked every PCLK cycle, and a simple remote slave on ack_sclk.
`timescale 1ns/1ps
module tb_cmd_handshake_src;
    localparam int CW = 3, AW = 10, DW = 10, SS = 2, DEPTH = 4, TO = 16;
    localparam int GUARD = 2 * SS + 2;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
    } cmd_t;

    logic          PCLK = 1'b0, RESETn_pclk = 1'b0, cmd_valid = 1'b0, ABORT = 1'b0;
    logic [CW-1:0] CMD = '0;
    logic [AW-1:0] ADDR = '0;
    logic [DW-1:0] WDATA = '0;
    logic          ack_sclk = 1'b0;
    logic [DW-1:0] RDATA_sclk = '0;
    logic          cmd_ready, req_pclk, rsp_valid, RESP_pclk, busy;
    logic [CW-1:0] CMD_REG_pclk;
    logic [AW-1:0] ADDR_REG_pclk;
    logic [DW-1:0] WDATA_REG_pclk, RDATA_pclk;

    cmd_handshake_src #(
        .CW(CW), .AW(AW), .DW(DW), .SYNC_STAGES(SS), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .RESETn_pclk(RESETn_pclk), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .CMD(CMD), .ADDR(ADDR), .WDATA(WDATA), .ABORT(ABORT),
        .CMD_REG_pclk(CMD_REG_pclk), .ADDR_REG_pclk(ADDR_REG_pclk),
        .WDATA_REG_pclk(WDATA_REG_pclk), .req_pclk(req_pclk), .ack_sclk(ack_sclk),
        .RDATA_sclk(RDATA_sclk), .rsp_valid(rsp_valid), .RDATA_pclk(RDATA_pclk),
        .RESP_pclk(RESP_pclk), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0, errors = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- model state ----------------
    cmd_t          m_q[$];
    cmd_t          m_reg = '0;
    bit            ack_log[int];
    bit            m_active = 0, m_launched = 0, m_dropping = 0;
    bit            m_req = 0, m_rsp = 0, m_resp = 0, m_ready = 0, m_busy = 0;
    logic [DW-1:0] m_rdata = '0;
    int            t_rise = 0, t_last_high = 0;
    bit            rdy_edge, a_seen;

    // ---------------- observations ----------------
    int            rise_log[$], fall_log[$];
    logic [CW-1:0] launch_cmds[$];
    int            rsp_cnt = 0, err_cnt = 0, ack_rise_edge = -1;
    logic [DW-1:0] last_rdata = '0;
    logic          last_resp = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;

    always @(posedge PCLK) begin
        #1;
        cyc++;
        rdy_edge = (m_q.size() < DEPTH);
        // the FSM acts on the ack value sampled SS edges earlier
        a_seen = ack_log.exists(cyc - SS) ? ack_log[cyc - SS] : 1'b0;
        if (!RESETn_pclk) begin
            for (int k = 0; k < SS; k++) ack_log[cyc - k] = 1'b0;
            m_q.delete();
            m_active = 0; m_launched = 0; m_dropping = 0;
            m_req = 0; m_rsp = 0; m_resp = 0; m_rdata = '0; m_reg = '0;
        end else begin
            ack_log[cyc] = ack_sclk;
            m_rsp = 0;
            if (!m_active) begin
                if (!ABORT && m_q.size() > 0) begin
                    m_reg = m_q.pop_front();
                    m_active = 1; m_launched = 0; m_dropping = 0;
                end
            end else if (!m_launched) begin
                if (ABORT) m_active = 0;
                else begin
                    m_req = 1; m_launched = 1; t_rise = cyc;
                end
            end else if (!m_dropping) begin
                if (a_seen) begin
                    m_rsp = 1; m_resp = 0; m_rdata = RDATA_sclk;
                end else if (ABORT || (cyc - t_rise == TO)) begin
                    m_rsp = 1; m_resp = 1; m_rdata = '0;
                end
                if (m_rsp) begin
                    m_req = 0; m_dropping = 1; t_last_high = cyc;
                end
            end else begin
                if (a_seen) t_last_high = cyc;
                else if (cyc - t_last_high == GUARD) m_active = 0;
            end
            if (ABORT) m_q.delete();
            if (cmd_valid && rdy_edge && !ABORT && CMD != '0) m_q.push_back(cmd_t'({CMD, ADDR, WDATA}));
        end
        m_ready = RESETn_pclk && (m_q.size() < DEPTH);
        m_busy  = m_active || (m_q.size() > 0);

        check("req_pclk", req_pclk, m_req);
        check("rsp_valid", rsp_valid, m_rsp);
        check("cmd_ready", cmd_ready, m_ready);
        check("busy", busy, m_busy);
        check("cmd_reg", CMD_REG_pclk, m_reg.c);
        check("addr_reg", ADDR_REG_pclk, m_reg.a);
        check("wdata_reg", WDATA_REG_pclk, m_reg.w);
        if (m_rsp || !RESETn_pclk) begin
            check("resp", RESP_pclk, m_resp);
            check("rdata", RDATA_pclk, m_rdata);
        end

        if (req_pclk && !prev_req) begin
            rise_log.push_back(cyc);
            launch_cmds.push_back(CMD_REG_pclk);
        end
        if (!req_pclk && prev_req) fall_log.push_back(cyc);
        if (rsp_valid) begin
            rsp_cnt++;
            if (RESP_pclk) err_cnt++;
            last_rdata = RDATA_pclk;
            last_resp  = RESP_pclk;
        end
        if (ack_sclk && !prev_ack) ack_rise_edge = cyc;
        prev_req = req_pclk;
        prev_ack = ack_sclk;
    end

    // ---------------- remote slave ----------------
    bit slave_en = 0;
    int slave_lo = 0, slave_hi = 0;

    initial begin : slave
        int d;
        forever begin
            @(negedge PCLK);
            if (slave_en && req_pclk && !ack_sclk) begin
                d = $urandom_range(slave_hi, slave_lo);
                repeat (d) @(negedge PCLK);
                if (slave_en && req_pclk) begin
                    RDATA_sclk = ADDR_REG_pclk ^ WDATA_REG_pclk;
                    ack_sclk   = 1'b1;
                end
            end else if (ack_sclk && !req_pclk) begin
                d = $urandom_range(slave_hi, slave_lo);
                repeat (d) @(negedge PCLK);
                ack_sclk = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    int pushed_edge = 0;

    task automatic push(input logic [CW-1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] w);
        int n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 300) check("push_wait_ready", cmd_ready, 1);
        CMD = c; ADDR = a; WDATA = w; cmd_valid = 1'b1;
        @(posedge PCLK);
        #2 pushed_edge = cyc;
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge PCLK);
        while (busy && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        check("idle_wait", busy, 0);
    endtask

    task automatic wait_req_high(input int budget);
        int n = 0;
        while (!req_pclk && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        check("req_wait", req_pclk, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, %0d checks, %0d errors so far", checks, errors);
        $fatal(1);
    end

    initial begin
        int r0, e0, base, nz;
        logic [CW-1:0] c;
        repeat (3) @(negedge PCLK);
        check("rst_req", req_pclk, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_busy", busy, 0);
        RESETn_pclk = 1'b1;
        @(negedge PCLK);

        // 1: single command, ack returns 0x2AA (slave echoes ADDR ^ WDATA)
        slave_en = 1; slave_lo = 0; slave_hi = 0;
        r0 = rsp_cnt; base = rise_log.size();
        push(3'd1, 10'h155, 10'h3FF);
        wait_idle(100);
        check("t1_req_count", rise_log.size() - base, 1);
        if (rise_log.size() > base) begin
            check("t1_req_latency", rise_log[base], pushed_edge + 2);
            check("t1_rsp_latency", fall_log[base], ack_rise_edge + SS);
        end
        check("t1_rsp_count", rsp_cnt - r0, 1);
        check("t1_rdata", last_rdata, 10'h2AA);
        check("t1_resp", last_resp, 0);

        // 2: ack withheld, queue fills, then release
        slave_en = 0; slave_lo = 1; slave_hi = 3;
        r0 = rsp_cnt; e0 = err_cnt; base = launch_cmds.size();
        for (int i = 0; i < 5; i++) push(CW'(i + 1), AW'(10'h10 + i), DW'(10'h20 * i));
        check("t2_ready_full", cmd_ready, 0);
        CMD = 3'd6; ADDR = 10'h3A; WDATA = 10'h3B; cmd_valid = 1'b1;
        repeat (3) @(negedge PCLK);
        cmd_valid = 1'b0;
        slave_en = 1;
        wait_idle(400);
        check("t2_rsp_count", rsp_cnt - r0, 5);
        check("t2_err_count", err_cnt - e0, 0);
        check("t2_launch_count", launch_cmds.size() - base, 5);
        if (launch_cmds.size() >= base + 5)
            for (int i = 0; i < 5; i++) check("t2_order", launch_cmds[base + i], i + 1);

        // 3: timeout with no ack, twice back to back
        slave_en = 0;
        r0 = rsp_cnt; e0 = err_cnt; base = rise_log.size();
        push(3'd2, 10'h0AA, 10'h055);
        push(3'd3, 10'h1AA, 10'h001);
        wait_idle(200);
        check("t3_req_count", rise_log.size() - base, 2);
        if (rise_log.size() >= base + 2 && fall_log.size() >= base + 2) begin
            check("t3_high_len", fall_log[base] - rise_log[base], TO);
            check("t3_gap_ge_guard", (rise_log[base + 1] - fall_log[base]) >= GUARD, 1);
        end
        check("t3_err_count", err_cnt - e0, 2);
        check("t3_rdata", last_rdata, 0);
        check("t3_resp", last_resp, 1);

        // 4: abort while requesting with 3 queued
        r0 = rsp_cnt;
        for (int i = 0; i < 4; i++) push(CW'(i + 4), AW'(10'h200 + i), DW'(10'h100 + i));
        wait_req_high(20);
        ABORT = 1'b1;
        @(negedge PCLK);
        ABORT = 1'b0;
        wait_idle(100);
        base = rise_log.size();
        repeat (20) @(negedge PCLK);
        check("t4_rsp_count", rsp_cnt - r0, 1);
        check("t4_resp", last_resp, 1);
        check("t4_no_req", rise_log.size() - base, 0);
        check("t4_busy", busy, 0);

        // 5: IDLE command, then reset in the middle of a request
        base = rise_log.size();
        push(3'd0, 10'h3FF, 10'h3FF);
        repeat (10) @(negedge PCLK);
        check("t5_idle_no_req", rise_log.size() - base, 0);
        check("t5_idle_busy", busy, 0);
        r0 = rsp_cnt;
        push(3'd5, 10'h123, 10'h321);
        wait_req_high(20);
        RESETn_pclk = 1'b0;
        @(posedge PCLK);
        #2;
        check("t5_rst_req", req_pclk, 0);
        check("t5_rst_rsp", rsp_valid, 0);
        check("t5_rst_cmd_reg", CMD_REG_pclk, 0);
        check("t5_rst_addr_reg", ADDR_REG_pclk, 0);
        check("t5_rst_ready", cmd_ready, 0);
        check("t5_rst_busy", busy, 0);
        repeat (2) @(negedge PCLK);
        RESETn_pclk = 1'b1;
        repeat (4) @(negedge PCLK);
        check("t5_no_rsp", rsp_cnt - r0, 0);

        // 6: 200 random commands against the slave with random response delays
        slave_en = 1; slave_lo = 0; slave_hi = 5;
        r0 = rsp_cnt; e0 = err_cnt; base = launch_cmds.size(); nz = 0;
        for (int i = 0; i < 200; i++) begin
            c = CW'($urandom_range(7, 0));
            if (c != '0) nz++;
            push(c, AW'($urandom), DW'($urandom));
            repeat ($urandom_range(2, 0)) @(negedge PCLK);
        end
        wait_idle(2000);
        check("t6_launch_count", launch_cmds.size() - base, nz);
        check("t6_rsp_count", rsp_cnt - r0, nz);
        check("t6_err_count", err_cnt - e0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
